// File: rtl/spi_slave_regfile.sv
// SPI slave register-file back end: decodes CS frames (command byte, then data bytes) into
// writes and read loads on a 2**ADDR_W x 8 bank. Define SPI_RF_WRITE_LOCK_EN to make reg[0][0] a write lock.
module spi_slave_regfile #(
  parameter int ADDR_W = 4
) (
  input  logic              SCLK,
  input  logic              reset,
  input  logic              CS,
  input  logic              MOSI,
  output logic [7:0]        slaveDataToSend,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [7:0]        host_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_CMD = 2'd0,
    ST_WR  = 2'd1,
    ST_RD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        sr_q, sr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        sdts_q, sdts_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];

  logic              frame_clr_s;
  logic [7:0]        byte_s;
  logic              byte_done_s;
  logic              write_ok_s;
  logic              wr_en_s;
  logic              rd_load_s;

  // Frame-level state is wiped both by reset and by CS going inactive.
  assign frame_clr_s = reset | CS;
  assign byte_s      = {MOSI, sr_q};
  assign byte_done_s = (bit_cnt_q == 3'd7);

`ifdef SPI_RF_WRITE_LOCK_EN
  assign write_ok_s = (ptr_q == {ADDR_W{1'b0}}) || (mem_q[0][0] == 1'b0);
`else
  assign write_ok_s = 1'b1;
`endif

  // Frame state register, bit counter, shifter, pointer and write strobe.
  always_ff @(negedge SCLK or posedge frame_clr_s) begin
    if (frame_clr_s) begin
      state_q    <= ST_CMD;
      bit_cnt_q  <= 3'd0;
      sr_q       <= 7'd0;
      ptr_q      <= {ADDR_W{1'b0}};
      wr_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      ptr_q      <= ptr_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Next frame state: only a completed command byte moves the machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CMD: begin
        if (byte_done_s) begin
          state_d = byte_s[7] ? ST_WR : ST_RD;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_WR:   state_d = ST_WR;
      ST_RD:   state_d = ST_RD;
      default: state_d = ST_CMD;
    endcase
  end

  // Per-state actions on byte completion: address capture, read load, burst write.
  always_comb begin
    wr_en_s   = 1'b0;
    rd_load_s = 1'b0;
    ptr_d     = ptr_q;
    case (state_q)
      ST_CMD: begin
        if (byte_done_s) begin
          ptr_d     = byte_s[ADDR_W-1:0];
          rd_load_s = ~byte_s[7];
        end else begin
          ptr_d     = ptr_q;
        end
      end
      ST_WR: begin
        if (byte_done_s) begin
          wr_en_s = write_ok_s;
          ptr_d   = ptr_q + ADDR_W'(1);
        end else begin
          ptr_d   = ptr_q;
        end
      end
      default: begin
        wr_en_s   = 1'b0;
        rd_load_s = 1'b0;
      end
    endcase
  end

  // Datapath next values for shifter, bank, read response and write report.
  always_comb begin
    bit_cnt_d  = bit_cnt_q + 3'd1;
    sr_d       = byte_s[7:1];
    mem_d      = mem_q;
    wr_pulse_d = wr_en_s;
    if (wr_en_s) begin
      mem_d[ptr_q] = byte_s;
      wr_addr_d    = ptr_q;
    end else begin
      wr_addr_d    = wr_addr_q;
    end
    if (rd_load_s) begin
      sdts_d = mem_q[byte_s[ADDR_W-1:0]];
    end else begin
      sdts_d = sdts_q;
    end
  end

  // Bank and read response survive CS deassertion; only reset clears them.
  always_ff @(negedge SCLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      sdts_q    <= 8'h00;
      wr_addr_q <= {ADDR_W{1'b0}};
    end else begin
      mem_q     <= mem_d;
      sdts_q    <= sdts_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign slaveDataToSend = sdts_q;
  assign wr_pulse        = wr_pulse_q;
  assign wr_addr         = wr_addr_q;
  assign host_rdata      = mem_q[host_addr];

endmodule
